// File: rtl/regfile_write_ctrl.sv
// Windowed register-file write-port controller: CWP mapping, Le/D drive, SAVE/RESTORE traps.
// Optional RF_WCOUNT_EN adds the wcount output counting non-zero Le pulses.
module regfile_write_ctrl #(
    parameter  int NWINDOWS = 8,
    localparam int NREGS    = 8 + 16 * NWINDOWS,
    localparam int CW       = $clog2(NWINDOWS)
) (
    input  logic                Clk,
    input  logic                Clr,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [4:0]          req_rd,
    input  logic [31:0]         req_data,
    input  logic                save,
    input  logic                restore,
    input  logic [NWINDOWS-1:0] wim,
    input  logic                trap_ack,
    output logic [CW-1:0]       cwp,
    output logic                trap_ovf,
    output logic                trap_unf,
    output logic [31:0]         D,
`ifdef RF_WCOUNT_EN
    output logic [31:0]         wcount,
`endif
    output logic [NREGS-1:0]    Le
);

    localparam int PW = $clog2(NREGS);

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cwp;
    logic [CW-1:0]    w_cwp_nxt;
    logic [CW-1:0]    w_cwp_dec;
    logic [CW-1:0]    w_cwp_inc;
    logic             r_ovf;
    logic             r_unf;
    logic             w_ovf_nxt;
    logic             w_unf_nxt;
    logic             w_accept;
    logic             w_wr;
    logic [PW-1:0]    w_phys;
    logic [NREGS-1:0] r_le;
    logic [NREGS-1:0] w_le_nxt;
    logic [31:0]      r_d;

    assign req_ready = ~Clr & (r_state == RUN);
    assign w_accept  = req_valid & req_ready;
    assign w_wr      = w_accept & (req_rd != 5'd0);
    assign w_cwp_dec = r_cwp - CW'(1);
    assign w_cwp_inc = r_cwp + CW'(1);

    // Ins alias the outs of the next window up; globals bypass the window.
    always_comb begin
        w_phys = PW'(req_rd);
        unique case (1'b1)
            (req_rd[4:3] == 2'b00):
                w_phys = PW'(req_rd);
            (req_rd[4:3] == 2'b11):
                w_phys = PW'(8) + (PW'(w_cwp_inc) << 4)
                       + PW'(req_rd[2:0]);
            default:
                w_phys = PW'(8) + (PW'(r_cwp) << 4)
                       + PW'(req_rd - 5'd8);
        endcase
    end

    always_comb begin
        w_le_nxt = '0;
        if (w_wr) begin
            w_le_nxt[w_phys] = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_le <= '0;
            r_d  <= '0;
        end else begin
            r_le <= w_le_nxt;
            if (w_wr) begin
                r_d <= req_data;
            end
        end
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_state <= RUN;
            r_cwp   <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cwp   <= w_cwp_nxt;
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cwp_nxt   = r_cwp;
        w_ovf_nxt   = r_ovf;
        w_unf_nxt   = r_unf;
        unique case (r_state)
            RUN: begin
                if (save & ~restore) begin
                    if (wim[w_cwp_dec]) begin
                        w_ovf_nxt   = 1'b1;
                        w_state_nxt = TRAP;
                    end else begin
                        w_cwp_nxt = w_cwp_dec;
                    end
                end else if (restore & ~save) begin
                    if (wim[w_cwp_inc]) begin
                        w_unf_nxt   = 1'b1;
                        w_state_nxt = TRAP;
                    end else begin
                        w_cwp_nxt = w_cwp_inc;
                    end
                end
            end
            TRAP: begin
                if (trap_ack) begin
                    w_ovf_nxt   = 1'b0;
                    w_unf_nxt   = 1'b0;
                    w_state_nxt = RUN;
                end
            end
        endcase
    end

`ifdef RF_WCOUNT_EN
    logic [31:0] r_wcount;

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_wcount <= '0;
        end else if (w_wr && (r_wcount != 32'hFFFF_FFFF)) begin
            r_wcount <= r_wcount + 32'd1;
        end
    end

    assign wcount = r_wcount;
`endif

    assign cwp      = r_cwp;
    assign trap_ovf = r_ovf;
    assign trap_unf = r_unf;
    assign D        = r_d;
    assign Le       = r_le;

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Bench for regfile_write_ctrl: directed cases plus random traffic against a behavioural model.
module tb_regfile_write_ctrl;

    localparam int N  = 8;
    localparam int NR = 8 + 16 * N;
    localparam int CW = 3;

    logic          Clk = 1'b0;
    logic          Clr;
    logic          req_valid;
    logic          req_ready;
    logic [4:0]    req_rd;
    logic [31:0]   req_data;
    logic          save;
    logic          restore;
    logic [N-1:0]  wim;
    logic          trap_ack;
    logic [CW-1:0] cwp;
    logic          trap_ovf;
    logic          trap_unf;
    logic [31:0]   D;
    logic [NR-1:0] Le;
`ifdef RF_WCOUNT_EN
    logic [31:0]   wcount;
`endif

    regfile_write_ctrl #(.NWINDOWS(N)) dut (
        .Clk       (Clk),
        .Clr       (Clr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .save      (save),
        .restore   (restore),
        .wim       (wim),
        .trap_ack  (trap_ack),
        .cwp       (cwp),
        .trap_ovf  (trap_ovf),
        .trap_unf  (trap_unf),
        .D         (D),
`ifdef RF_WCOUNT_EN
        .wcount    (wcount),
`endif
        .Le        (Le)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    task automatic chk(input string nm, input logic [NR-1:0] act,
                       input logic [NR-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int phys(input int rd, input int w);
        if (rd < 8) return rd;
        if (rd < 24) return 8 + 16 * w + (rd - 8);
        return 8 + 16 * ((w + 1) % N) + (rd - 24);
    endfunction

    function automatic logic [NR-1:0] onehot(input int idx);
        logic [NR-1:0] v;
        v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    // Behavioural model: window pointer as an integer, pending pulse as an index.
    int          m_cwp;
    bit          m_trap;
    bit          m_ovf;
    bit          m_unf;
    int          m_idx;
    logic [31:0] m_d;
    longint      m_wc;

    always @(posedge Clk or posedge Clr) begin
        automatic int     n;
        automatic int     cw;
        automatic int     idx;
        automatic bit     tr;
        automatic bit     ov;
        automatic bit     un;
        automatic logic [31:0] d;
        automatic longint wc;
        if (Clr) begin
            m_cwp  <= 0;
            m_trap <= 1'b0;
            m_ovf  <= 1'b0;
            m_unf  <= 1'b0;
            m_idx  <= -1;
            m_d    <= '0;
            m_wc   <= 0;
        end else begin
            cw = m_cwp; tr = m_trap; ov = m_ovf; un = m_unf;
            d = m_d; wc = m_wc; idx = -1;
            if (req_valid && !m_trap && req_rd != 0) begin
                idx = phys(int'(req_rd), m_cwp);
                d = req_data;
                if (wc < 64'hFFFF_FFFF) wc++;
            end
            if (!m_trap) begin
                if (save && !restore) begin
                    n = (m_cwp + N - 1) % N;
                    if (wim[n]) begin ov = 1'b1; tr = 1'b1; end
                    else cw = n;
                end else if (restore && !save) begin
                    n = (m_cwp + 1) % N;
                    if (wim[n]) begin un = 1'b1; tr = 1'b1; end
                    else cw = n;
                end
            end else if (trap_ack) begin
                tr = 1'b0; ov = 1'b0; un = 1'b0;
            end
            m_cwp  <= cw;
            m_trap <= tr;
            m_ovf  <= ov;
            m_unf  <= un;
            m_idx  <= idx;
            m_d    <= d;
            m_wc   <= wc;
        end
    end

    always @(negedge Clk) begin
        if (cmp_en) begin
            chk("le", Le, onehot(m_idx));
            chk("d", NR'(D), NR'(m_d));
            chk("cwp", NR'(cwp), NR'(m_cwp));
            chk("ovf", NR'(trap_ovf), NR'(m_ovf));
            chk("unf", NR'(trap_unf), NR'(m_unf));
            chk("ready", NR'(req_ready), NR'(!Clr && !m_trap));
`ifdef RF_WCOUNT_EN
            chk("wcount", NR'(wcount), NR'(m_wc));
`endif
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic strobe(input bit s, input bit r, input logic [N-1:0] m);
        wim = m; save = s; restore = r;
        tick();
        save = 1'b0; restore = 1'b0;
    endtask

`ifdef RF_WCOUNT_EN
    logic [31:0] wc0;
`endif

    initial begin
        Clr = 1'b1; req_valid = 1'b0; req_rd = '0; req_data = '0;
        save = 1'b0; restore = 1'b0; wim = '0; trap_ack = 1'b0;
        repeat (2) tick();
        cmp_en = 1'b1;
        chk("rst_le", Le, '0);
        chk("rst_d", NR'(D), '0);
        chk("rst_cwp", NR'(cwp), '0);
        chk("rst_ready", NR'(req_ready), '0);
        Clr = 1'b0;
        tick();

        req_valid = 1'b1; req_rd = 5'd17; req_data = 32'hAAAA_AAAA;
        tick();
        req_valid = 1'b0;
        chk("w17_le", Le, onehot(17));
        chk("w17_d", NR'(D), NR'(32'hAAAA_AAAA));
        tick();
        chk("w17_idle", Le, '0);

        strobe(1'b1, 1'b0, '0);
        chk("save_wrap_cwp", NR'(cwp), NR'(7));
        req_valid = 1'b1; req_rd = 5'd25; req_data = 32'hABCD_EF78;
        tick();
        req_valid = 1'b0;
        chk("w25_le9", Le, onehot(9));
        chk("w25_d", NR'(D), NR'(32'hABCD_EF78));
        strobe(1'b0, 1'b1, '0);
        chk("restore_wrap_cwp", NR'(cwp), '0);

        strobe(1'b1, 1'b0, 8'h80);
        chk("ovf_flag", NR'(trap_ovf), NR'(1));
        chk("ovf_cwp", NR'(cwp), '0);
        chk("ovf_ready", NR'(req_ready), '0);
        req_valid = 1'b1; req_rd = 5'd8;
        repeat (2) tick();
        chk("trap_no_le", Le, '0);
        req_valid = 1'b0; trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;
        chk("ack_ovf", NR'(trap_ovf), '0);
        chk("ack_ready", NR'(req_ready), NR'(1));

        strobe(1'b1, 1'b0, '0);
        strobe(1'b0, 1'b1, 8'h01);
        chk("unf_flag", NR'(trap_unf), NR'(1));
        chk("unf_cwp", NR'(cwp), NR'(7));
        trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;
        strobe(1'b0, 1'b1, '0);
        chk("restore7_cwp", NR'(cwp), '0);
        strobe(1'b1, 1'b1, 8'hFF);
        chk("both_cwp", NR'(cwp), '0);
        chk("both_ovf", NR'(trap_ovf), '0);

`ifdef RF_WCOUNT_EN
        wc0 = wcount;
`endif
        req_valid = 1'b1; req_data = 32'h7777_7777; req_rd = 5'd1;
        tick();
        chk("b2b_le1", Le, onehot(1));
        req_rd = 5'd2;
        tick();
        chk("b2b_le2", Le, onehot(2));
        req_rd = 5'd0;
        tick();
        req_valid = 1'b0;
        chk("b2b_r0", Le, '0);
        chk("b2b_d", NR'(D), NR'(32'h7777_7777));
`ifdef RF_WCOUNT_EN
        chk("wcount_delta", NR'(wcount - wc0), NR'(2));
`endif

        strobe(1'b1, 1'b0, '0);
        req_valid = 1'b1; req_rd = 5'd5; req_data = 32'h5555_0005;
        tick();
        req_valid = 1'b0;
        chk("clr_pre_le5", Le, onehot(5));
        #2 Clr = 1'b1;
        #1;
        chk("clr_le", Le, '0);
        chk("clr_cwp", NR'(cwp), '0);
        chk("clr_flags", NR'({trap_ovf, trap_unf}), '0);
        @(posedge Clk);
        #1 Clr = 1'b0;
        tick();
        chk("clr_no_replay", Le, '0);

        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom % 10) < 7;
            req_rd    = 5'($urandom);
            req_data  = $urandom;
            save      = ($urandom % 6) == 0;
            restore   = ($urandom % 6) == 0;
            trap_ack  = ($urandom % 4) == 0;
            wim       = (($urandom % 3) == 0) ? N'($urandom & $urandom) : '0;
            Clr       = ($urandom % 150) == 0;
            tick();
        end
        Clr = 1'b0; req_valid = 1'b0; save = 1'b0; restore = 1'b0;
        trap_ack = 1'b0;
        tick();
        @(negedge Clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
